// File: rtl/stage_mem_sb.sv
// Memory stage with a FIFO store buffer between execute and write.
// Loads are aligned and extended here; misaligned accesses retire as nops.
module stage_mem_sb #(
  parameter int XLEN     = 32,
  parameter int SB_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_valid,
  input  logic [XLEN-1:0]   mem_pc,
  input  logic [XLEN-1:0]   mem_data0,
  input  logic [XLEN-1:0]   mem_data1,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              mem_fence,
  input  logic              mem_extend,
  input  logic [1:0]        mem_width,
  input  logic              mem_jmp,
  input  logic              mem_br,
  input  logic              mem_br_inv,
  input  logic [4:0]        wb_reg,
  input  logic              wb_stall,
  output logic              req,
  output logic [XLEN-1:0]   addr,
  output logic              write,
  output logic [XLEN-1:0]   data_out,
  output logic [XLEN/8-1:0] byte_en,
  input  logic              ack,
  input  logic [XLEN-1:0]   data_in,
  output logic              mem_wen,
  output logic              fe_enable,
  output logic              pc_wen,
  output logic [XLEN-1:0]   pc,
  output logic              mem_stall,
  output logic              mem_misalign,
  output logic              sb_empty,
  output logic              wb_valid,
  output logic [XLEN-1:0]   wb_pc,
  output logic [4:0]        wb_reg_r,
  output logic [XLEN-1:0]   wb_data
);
  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);
  localparam int AW = $clog2(SB_DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, DRAIN = 2'd2} state_t;

  function automatic logic [NB-1:0] lane_mask(input logic [1:0] w);
    case (w)
      2'd0:    lane_mask = NB'(1);
      2'd1:    lane_mask = NB'(3);
      default: lane_mask = {NB{1'b1}};
    endcase
  endfunction

  function automatic logic [XLEN-1:0] load_align(input logic [XLEN-1:0] v, input logic [1:0] w,
                                                 input logic ext);
    case (w)
      2'd0:    load_align = {{(XLEN-8){ext & v[7]}}, v[7:0]};
      2'd1:    load_align = {{(XLEN-16){ext & v[15]}}, v[15:0]};
      default: load_align = v;
    endcase
  endfunction

  state_t            state;
  logic [XLEN-1:0]   sb_addr [SB_DEPTH];
  logic [XLEN-1:0]   sb_data [SB_DEPTH];
  logic [NB-1:0]     sb_be   [SB_DEPTH];
  logic [SB_DEPTH-1:0] sb_vld;
  logic [PW-1:0]     wr_ptr, rd_ptr;

  logic [OW-1:0]     off;
  logic [XLEN-1:0]   word_addr, push_data, load_val;
  logic [NB-1:0]     push_be;
  logic [AW-1:0]     wr_idx, rd_idx;
  logic              ld, st, full, pop, push, ld_done, ld_go, hazard;

  assign off       = mem_data0[OW-1:0];
  assign word_addr = {mem_data0[XLEN-1:OW], {OW{1'b0}}};
  assign push_data = mem_data1 << {off, 3'b000};
  assign push_be   = lane_mask(mem_width) << off;
  assign load_val  = load_align(data_in >> {off, 3'b000}, mem_width, mem_extend);
  assign wr_idx    = wr_ptr[AW-1:0];
  assign rd_idx    = rd_ptr[AW-1:0];

  assign mem_misalign = mem_valid & (mem_read | mem_write) &
                        (((mem_width == 2'd1) & mem_data0[0]) |
                         ((mem_width == 2'd2) & (mem_data0[1:0] != 2'b00)));
  assign ld       = mem_valid & mem_read & ~mem_misalign;
  assign st       = mem_valid & mem_write & ~mem_misalign;
  assign sb_empty = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) & (wr_idx == rd_idx);
  assign pop      = (state == DRAIN) & ack;
  assign ld_done  = (state == LOAD) & ack;
  assign push     = st & ~wb_stall & (~full | pop);
  assign ld_go    = ld & ~hazard & ~wb_stall;

  // Load hazard: any buffered store to the same word blocks the load until drained.
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      hazard = hazard | (sb_vld[i] & (sb_addr[i] == word_addr));
    end
  end

  assign mem_stall = mem_valid & (wb_stall | (st & full & ~pop) | (ld & ~ld_done) |
                                  (mem_fence & ~sb_empty));
  assign mem_wen   = mem_valid & ~mem_read & ~mem_write & (wb_reg != 5'd0);
  assign fe_enable = mem_valid & (mem_jmp | mem_br);
  assign pc_wen    = mem_valid & (mem_jmp | (mem_br & (mem_data0[0] ^ mem_br_inv)));
  assign pc        = mem_data1;

  // Store buffer payload; only valid bits and pointers need reset.
  always_ff @(posedge clk) begin
    if (push) begin
      sb_addr[wr_idx] <= word_addr;
      sb_data[wr_idx] <= push_data;
      sb_be[wr_idx]   <= push_be;
    end
  end

  // Store buffer pointers and valid bits; a push into the slot being popped wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      sb_vld <= '0;
    end else begin
      if (pop) begin
        rd_ptr         <= rd_ptr + PW'(1);
        sb_vld[rd_idx] <= 1'b0;
      end
      if (push) begin
        wr_ptr         <= wr_ptr + PW'(1);
        sb_vld[wr_idx] <= 1'b1;
      end
    end
  end

  // Bus FSM; an empty buffer being pushed drains straight from the incoming store.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      req      <= 1'b0;
      addr     <= '0;
      write    <= 1'b0;
      data_out <= '0;
      byte_en  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ld_go) begin
            state    <= LOAD;
            req      <= 1'b1;
            addr     <= word_addr;
            write    <= 1'b0;
            data_out <= '0;
            byte_en  <= push_be;
          end else if (~sb_empty | push) begin
            state    <= DRAIN;
            req      <= 1'b1;
            addr     <= sb_empty ? word_addr : sb_addr[rd_idx];
            write    <= 1'b1;
            data_out <= sb_empty ? push_data : sb_data[rd_idx];
            byte_en  <= sb_empty ? push_be : sb_be[rd_idx];
          end else begin
            req <= 1'b0;
          end
        end
        LOAD, DRAIN: begin
          if (ack) begin
            state <= IDLE;
            req   <= 1'b0;
            write <= 1'b0;
          end else begin
            req <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          req   <= 1'b0;
        end
      endcase
    end
  end

  // Write-stage registers, frozen while the write stage is stalled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_valid <= 1'b0;
      wb_pc    <= '0;
      wb_reg_r <= 5'd0;
      wb_data  <= '0;
    end else if (!wb_stall) begin
      wb_valid <= mem_valid & ~mem_stall;
      wb_pc    <= mem_pc;
      wb_reg_r <= mem_misalign ? 5'd0 : wb_reg;
      wb_data  <= ld_done ? load_val : mem_data0;
    end else begin
      wb_valid <= wb_valid;
    end
  end
endmodule

// File: tb/tb_stage_mem_sb.sv
// Directed bench for stage_mem_sb: store buffer, load hazard/extension, misalign, fence, reset.
module tb_stage_mem_sb;
  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid, mem_read, mem_write, mem_fence, mem_extend, mem_jmp, mem_br, mem_br_inv;
  logic [31:0] mem_pc, mem_data0, mem_data1, data_in;
  logic [1:0]  mem_width;
  logic [4:0]  wb_reg;
  logic        wb_stall, ack;
  logic        req, write, mem_wen, fe_enable, pc_wen, mem_stall, mem_misalign, sb_empty, wb_valid;
  logic [31:0] addr, data_out, pc, wb_pc, wb_data;
  logic [3:0]  byte_en;
  logic [4:0]  wb_reg_r;
  int          checks = 0;
  int          failures = 0;

  stage_mem_sb #(.XLEN(32), .SB_DEPTH(4)) dut (
    .clk(clk), .reset(rst), .mem_valid(mem_valid), .mem_pc(mem_pc), .mem_data0(mem_data0),
    .mem_data1(mem_data1), .mem_read(mem_read), .mem_write(mem_write), .mem_fence(mem_fence),
    .mem_extend(mem_extend), .mem_width(mem_width), .mem_jmp(mem_jmp), .mem_br(mem_br),
    .mem_br_inv(mem_br_inv), .wb_reg(wb_reg), .wb_stall(wb_stall), .req(req), .addr(addr),
    .write(write), .data_out(data_out), .byte_en(byte_en), .ack(ack), .data_in(data_in),
    .mem_wen(mem_wen), .fe_enable(fe_enable), .pc_wen(pc_wen), .pc(pc), .mem_stall(mem_stall),
    .mem_misalign(mem_misalign), .sb_empty(sb_empty), .wb_valid(wb_valid), .wb_pc(wb_pc),
    .wb_reg_r(wb_reg_r), .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    mem_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; mem_fence = 1'b0; mem_extend = 1'b0;
    mem_jmp = 1'b0; mem_br = 1'b0; mem_br_inv = 1'b0; mem_width = 2'd0; wb_reg = 5'd0;
    mem_pc = 32'd0; mem_data0 = 32'd0; mem_data1 = 32'd0; wb_stall = 1'b0;
  endtask

  task automatic drive_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] w);
    clear_in();
    mem_valid = 1'b1; mem_write = 1'b1; mem_data0 = a; mem_data1 = d; mem_width = w;
  endtask

  task automatic drive_load(input logic [31:0] a, input logic [1:0] w, input logic ext,
                            input logic [4:0] rd);
    clear_in();
    mem_valid = 1'b1; mem_read = 1'b1; mem_data0 = a; mem_width = w; mem_extend = ext; wb_reg = rd;
  endtask

  task automatic wait_req(input string tag);
    for (int n = 0; n < 20 && !req; n++) tick();
    chk(tag, {31'd0, req}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    clear_in();
    ack = 1'b0; data_in = 32'd0; rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", {31'd0, req}, 32'd0);
    chk("rst_sb_empty", {31'd0, sb_empty}, 32'd1);
    chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    rst = 1'b0;
    tick();

    // sw 0xDEADBEEF @0x100, bus write appears one cycle later
    drive_store(32'h100, 32'hDEADBEEF, 2'd2);
    #1 chk("t1_no_stall", {31'd0, mem_stall}, 32'd0);
    tick(); clear_in();
    chk("t1_req", {31'd0, req}, 32'd1);
    chk("t1_write", {31'd0, write}, 32'd1);
    chk("t1_addr", addr, 32'h100);
    chk("t1_be", {28'd0, byte_en}, 32'hF);
    chk("t1_data", data_out, 32'hDEADBEEF);
    chk("t1_wb_valid", {31'd0, wb_valid}, 32'd1);
    ack = 1'b1; tick(); ack = 1'b0;
    chk("t1_req_done", {31'd0, req}, 32'd0);
    chk("t1_empty", {31'd0, sb_empty}, 32'd1);

    // fill the buffer with ack held low; fifth store stalls until the first ack
    for (int i = 0; i < 4; i++) begin
      drive_store(32'h10 + 32'(4 * i), 32'(i), 2'd2);
      #1 chk("t2_fill_stall", {31'd0, mem_stall}, 32'd0);
      tick();
    end
    drive_store(32'h20, 32'd4, 2'd2);
    #1 chk("t2_full_stall", {31'd0, mem_stall}, 32'd1);
    chk("t2_head_addr", addr, 32'h10);
    tick();
    chk("t2_still_stall", {31'd0, mem_stall}, 32'd1);
    ack = 1'b1;
    #1 chk("t2_push_on_pop", {31'd0, mem_stall}, 32'd0);
    tick(); ack = 1'b0; clear_in();
    for (int k = 1; k <= 4; k++) begin
      wait_req("t2_drain_req");
      chk("t2_drain_addr", addr, 32'h10 + 32'(4 * k));
      ack = 1'b1; tick(); ack = 1'b0;
    end
    chk("t2_empty", {31'd0, sb_empty}, 32'd1);

    // sb 0x80 @0x203, then lb @0x203 waits for the drain
    drive_store(32'h203, 32'h80, 2'd0);
    tick();
    chk("t3_st_addr", addr, 32'h200);
    chk("t3_st_be", {28'd0, byte_en}, 32'h8);
    chk("t3_st_data", data_out, 32'h80000000);
    drive_load(32'h203, 2'd0, 1'b1, 5'd5);
    #1 chk("t3_hazard_stall", {31'd0, mem_stall}, 32'd1);
    tick();
    chk("t3_hazard_hold", {31'd0, mem_stall & write}, 32'd1);
    ack = 1'b1; tick(); ack = 1'b0;
    chk("t3_idle_gap", {31'd0, req}, 32'd0);
    chk("t3_idle_stall", {31'd0, mem_stall}, 32'd1);
    tick();
    chk("t3_ld_req", {30'd0, req, write}, 32'd2);
    chk("t3_ld_addr", addr, 32'h200);
    data_in = 32'h80123456; ack = 1'b1;
    #1 chk("t3_ld_release", {31'd0, mem_stall}, 32'd0);
    tick(); ack = 1'b0; clear_in();
    chk("t3_lb_data", wb_data, 32'hFFFFFF80);
    chk("t3_lb_reg", {27'd0, wb_reg_r}, 32'd5);
    chk("t3_lb_valid", {31'd0, wb_valid}, 32'd1);

    // lhu @0x102 zero-extends the upper half
    drive_load(32'h102, 2'd1, 1'b0, 5'd6);
    tick();
    chk("t3_lhu_be", {28'd0, byte_en}, 32'hC);
    data_in = 32'h80010000; ack = 1'b1; tick(); ack = 1'b0; clear_in();
    chk("t3_lhu_data", wb_data, 32'h00008001);

    // misaligned lh and sw pass as nops with no bus traffic
    drive_load(32'h101, 2'd1, 1'b1, 5'd7);
    #1 chk("t4_misalign", {31'd0, mem_misalign}, 32'd1);
    chk("t4_no_stall", {31'd0, mem_stall}, 32'd0);
    tick(); clear_in();
    chk("t4_wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("t4_wb_reg", {27'd0, wb_reg_r}, 32'd0);
    chk("t4_no_req", {31'd0, req}, 32'd0);
    drive_store(32'h102, 32'h55, 2'd2);
    tick(); clear_in();
    chk("t4_sw_no_enq", {30'd0, sb_empty, req}, 32'd2);

    // branch/jump and ALU forwarding, then a write-stage stall hold
    mem_valid = 1'b1; mem_br = 1'b1; mem_data0 = 32'd1; mem_data1 = 32'h400;
    #1 chk("t5_br_taken", {29'd0, pc_wen, fe_enable, 1'b0}, 32'd6);
    chk("t5_pc", pc, 32'h400);
    mem_br_inv = 1'b1;
    #1 chk("t5_br_inv", {31'd0, pc_wen}, 32'd0);
    clear_in();
    mem_valid = 1'b1; mem_data0 = 32'h1234; wb_reg = 5'd3; mem_pc = 32'h48;
    #1 chk("t5_mem_wen", {31'd0, mem_wen}, 32'd1);
    tick();
    chk("t5_wb_data", wb_data, 32'h1234);
    chk("t5_wb_pc", wb_pc, 32'h48);
    chk("t5_wb_reg", {27'd0, wb_reg_r}, 32'd3);
    mem_data0 = 32'h5555; wb_stall = 1'b1;
    #1 chk("t5_wbs_stall", {31'd0, mem_stall}, 32'd1);
    tick();
    chk("t5_wb_hold", wb_data, 32'h1234);
    clear_in();

    // fence behind three queued stores
    for (int i = 0; i < 3; i++) begin
      drive_store(32'h300 + 32'(4 * i), 32'(i), 2'd2);
      tick();
    end
    clear_in(); mem_valid = 1'b1; mem_fence = 1'b1;
    #1 chk("t6_fence_stall", {31'd0, mem_stall}, 32'd1);
    for (int k = 0; k < 3; k++) begin
      wait_req("t6_req");
      chk("t6_addr", addr, 32'h300 + 32'(4 * k));
      ack = 1'b1; tick(); ack = 1'b0;
      if (k < 2) chk("t6_fence_wait", {31'd0, mem_stall}, 32'd1);
    end
    chk("t6_release", {30'd0, sb_empty, mem_stall}, 32'd2);
    tick(); clear_in();
    chk("t6_fence_wb", {31'd0, wb_valid}, 32'd1);

    // reset in the middle of a drain
    drive_store(32'h500, 32'h77, 2'd2);
    tick(); clear_in();
    chk("t7_pre_req", {31'd0, req}, 32'd1);
    rst = 1'b1;
    #1 chk("t7_req", {31'd0, req}, 32'd0);
    chk("t7_sb_empty", {31'd0, sb_empty}, 32'd1);
    chk("t7_wb_valid", {31'd0, wb_valid}, 32'd0);
    tick(); rst = 1'b0; tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
